// File: rtl/event_pkt_dispatcher_if.sv
// ============================================================================
// event_pkt_dispatcher_if : packet-in stream, forward/CPU output ports, stats
// Revision: 1.0
// ============================================================================
`default_nettype none

interface event_pkt_dispatcher_if #(
   parameter int W_PKT = 134
);
   logic             pkt_in_valid;
   logic [W_PKT-1:0] pkt_in;
   logic             fwd_valid;
   logic [W_PKT-1:0] fwd_data;
   logic             fwd_ready;
   logic             cpu_valid;
   logic [W_PKT-1:0] cpu_data;
   logic             cpu_ready;
   logic [31:0]      cnt_fwd;
   logic [31:0]      cnt_cpu;
   logic [31:0]      cnt_drop_full;
   logic [31:0]      cnt_drop_rate;

   // master is the dispatcher side, slave is the surrounding environment
   modport master (
      input  pkt_in_valid, pkt_in, fwd_ready, cpu_ready,
      output fwd_valid, fwd_data, cpu_valid, cpu_data,
      output cnt_fwd, cnt_cpu, cnt_drop_full, cnt_drop_rate
   );

   modport slave (
      output pkt_in_valid, pkt_in, fwd_ready, cpu_ready,
      input  fwd_valid, fwd_data, cpu_valid, cpu_data,
      input  cnt_fwd, cnt_cpu, cnt_drop_full, cnt_drop_rate
   );
endinterface

`default_nettype wire

// File: rtl/event_pkt_dispatcher.sv
// ============================================================================
// event_pkt_dispatcher : store-and-forward steering of packets to forward or
//                        rate-limited CPU port based on the head event bitmap
// Revision: 1.0
// ============================================================================
`default_nettype none

module event_pkt_dispatcher #(
   parameter int          W_PKT          = 134,
   parameter int          W_EVB          = 10,
   parameter int          B_EVB          = 64,
   parameter int          D_DATA_FIFO    = 8,
   parameter int          D_DESC_FIFO    = 4,
   parameter int          MAX_PKT_WORDS  = 98,
   parameter logic [31:0] TOKEN_INTERVAL = 32'd125000,
   parameter logic [7:0]  TOKEN_BURST    = 8'd16
) (
   input  wire logic              clk,
   input  wire logic              reset,
   event_pkt_dispatcher_if.master bus
);
   localparam int                    DATA_DEPTH    = 1 << D_DATA_FIFO;
   localparam int                    DESC_DEPTH    = 1 << D_DESC_FIFO;
   localparam int                    WCNT_W        = $clog2(MAX_PKT_WORDS + 1);
   localparam logic [D_DATA_FIFO:0]  DATA_DEPTH_C  = (D_DATA_FIFO+1)'(DATA_DEPTH);
   localparam logic [D_DATA_FIFO:0]  MAX_WORDS_C   = (D_DATA_FIFO+1)'(MAX_PKT_WORDS);
   localparam logic [D_DESC_FIFO:0]  DESC_DEPTH_C  = (D_DESC_FIFO+1)'(DESC_DEPTH);
   localparam logic [WCNT_W-1:0]     WCNT_LAST     = WCNT_W'(MAX_PKT_WORDS - 1);
   localparam logic [1:0]            TAG_HEAD      = 2'b01;
   localparam logic [1:0]            TAG_TAIL      = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACCEPT = 2'd1, W_DROP = 2'd2} wstate_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_SEND = 1'b1} rstate_t;

   logic [W_PKT-1:0]       r_data_mem [DATA_DEPTH];
   logic [D_DATA_FIFO-1:0] r_data_wr_ptr, r_data_rd_ptr;
   logic [D_DATA_FIFO:0]   r_data_cnt;
   logic                   r_desc_mem [DESC_DEPTH];
   logic [D_DESC_FIFO-1:0] r_desc_wr_ptr, r_desc_rd_ptr;
   logic [D_DESC_FIFO:0]   r_desc_cnt;
   logic                   r_push_pend, r_push_dest;
   wstate_t                r_wstate, w_wstate_nxt;
   rstate_t                r_rstate, w_rstate_nxt;
   logic [WCNT_W-1:0]      r_wcnt;
   logic                   r_acc_dest, r_rd_dest;
   logic [7:0]             r_tokens;
   logic [31:0]            r_tick_cnt;
   logic [31:0]            r_cnt_fwd, r_cnt_cpu, r_cnt_drop_full, r_cnt_drop_rate;

   logic [1:0]             w_in_tag;
   logic                   w_bitmap_hit, w_no_room, w_tick;
   logic                   w_wr_en, w_push_req, w_consume, w_inc_full, w_inc_rate;
   logic [W_PKT-1:0]       w_wr_data, w_head_word;
   logic                   w_pop, w_pkt_done;
   logic [8:0]             w_tok_sum;

   assign w_in_tag     = bus.pkt_in[W_PKT-1 -: 2];
   assign w_bitmap_hit = |bus.pkt_in[B_EVB +: W_EVB];
   // A descriptor waiting in r_push_pend already owns a slot
   assign w_no_room    = ((DATA_DEPTH_C - r_data_cnt) < MAX_WORDS_C) ||
                         ((r_desc_cnt + (D_DESC_FIFO+1)'(r_push_pend)) >= DESC_DEPTH_C);
   assign w_tick       = (r_tick_cnt == TOKEN_INTERVAL - 32'd1);
   assign w_head_word  = r_data_mem[r_data_rd_ptr];
   assign w_tok_sum    = {1'b0, r_tokens} + {8'd0, w_tick} - {8'd0, w_consume};

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_wr_en      = 1'b0;
      w_wr_data    = bus.pkt_in;
      w_push_req   = 1'b0;
      w_consume    = 1'b0;
      w_inc_full   = 1'b0;
      w_inc_rate   = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (bus.pkt_in_valid && w_in_tag == TAG_HEAD) begin
               if (w_no_room) begin
                  w_wstate_nxt = W_DROP;
                  w_inc_full   = 1'b1;
               end else if (w_bitmap_hit && r_tokens == 8'd0) begin
                  w_wstate_nxt = W_DROP;
                  w_inc_rate   = 1'b1;
               end else begin
                  w_wr_en      = 1'b1;
                  w_consume    = w_bitmap_hit;
                  w_wstate_nxt = W_ACCEPT;
               end
            end
         end
         W_ACCEPT: begin
            if (bus.pkt_in_valid) begin
               w_wr_en = 1'b1;
               if (w_in_tag == TAG_TAIL) begin
                  w_push_req   = 1'b1;
                  w_wstate_nxt = W_IDLE;
               end else if (r_wcnt == WCNT_LAST) begin
                  // Oversized packet: close it here, discard the rest
                  w_wr_data    = {TAG_TAIL, bus.pkt_in[W_PKT-3:0]};
                  w_push_req   = 1'b1;
                  w_wstate_nxt = W_DROP;
               end
            end
         end
         W_DROP: begin
            if (bus.pkt_in_valid && w_in_tag == TAG_TAIL) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_rstate_nxt  = r_rstate;
      w_pop         = 1'b0;
      w_pkt_done    = 1'b0;
      bus.fwd_valid = 1'b0;
      bus.cpu_valid = 1'b0;
      bus.fwd_data  = '0;
      bus.cpu_data  = '0;
      case (r_rstate)
         R_IDLE: if (r_desc_cnt != '0) w_rstate_nxt = R_SEND;
         R_SEND: begin
            if (r_rd_dest) begin
               bus.cpu_valid = 1'b1;
               bus.cpu_data  = w_head_word;
               w_pop         = bus.cpu_ready;
            end else begin
               bus.fwd_valid = 1'b1;
               bus.fwd_data  = w_head_word;
               w_pop         = bus.fwd_ready;
            end
            if (w_pop && w_head_word[W_PKT-1 -: 2] == TAG_TAIL) begin
               w_pkt_done   = 1'b1;
               w_rstate_nxt = R_IDLE;
            end
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_data_mem[r_data_wr_ptr] <= w_wr_data;
      if (r_push_pend) r_desc_mem[r_desc_wr_ptr] <= r_push_dest;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wstate        <= W_IDLE;
         r_rstate        <= R_IDLE;
         r_data_wr_ptr   <= '0;
         r_data_rd_ptr   <= '0;
         r_data_cnt      <= '0;
         r_desc_wr_ptr   <= '0;
         r_desc_rd_ptr   <= '0;
         r_desc_cnt      <= '0;
         r_push_pend     <= 1'b0;
         r_push_dest     <= 1'b0;
         r_wcnt          <= '0;
         r_acc_dest      <= 1'b0;
         r_rd_dest       <= 1'b0;
         r_tokens        <= TOKEN_BURST;
         r_tick_cnt      <= '0;
         r_cnt_fwd       <= '0;
         r_cnt_cpu       <= '0;
         r_cnt_drop_full <= '0;
         r_cnt_drop_rate <= '0;
      end else begin
         r_wstate    <= w_wstate_nxt;
         r_rstate    <= w_rstate_nxt;
         r_push_pend <= w_push_req;
         r_push_dest <= r_acc_dest;
         if (w_wr_en) begin
            r_data_wr_ptr <= r_data_wr_ptr + 1'b1;
            r_wcnt        <= (r_wstate == W_IDLE) ? WCNT_W'(1) : r_wcnt + 1'b1;
            if (r_wstate == W_IDLE) r_acc_dest <= w_bitmap_hit;
         end
         if (w_pop) r_data_rd_ptr <= r_data_rd_ptr + 1'b1;
         r_data_cnt <= r_data_cnt + (D_DATA_FIFO+1)'(w_wr_en) - (D_DATA_FIFO+1)'(w_pop);
         if (r_push_pend) r_desc_wr_ptr <= r_desc_wr_ptr + 1'b1;
         if (w_pkt_done)  r_desc_rd_ptr <= r_desc_rd_ptr + 1'b1;
         r_desc_cnt <= r_desc_cnt + (D_DESC_FIFO+1)'(r_push_pend)
                                  - (D_DESC_FIFO+1)'(w_pkt_done);
         if (r_rstate == R_IDLE && r_desc_cnt != '0) r_rd_dest <= r_desc_mem[r_desc_rd_ptr];
         r_tick_cnt <= w_tick ? 32'd0 : r_tick_cnt + 32'd1;
         r_tokens   <= (w_tok_sum > {1'b0, TOKEN_BURST}) ? TOKEN_BURST : w_tok_sum[7:0];
         if (w_pkt_done && !r_rd_dest) r_cnt_fwd <= r_cnt_fwd + 32'd1;
         if (w_pkt_done &&  r_rd_dest) r_cnt_cpu <= r_cnt_cpu + 32'd1;
         if (w_inc_full) r_cnt_drop_full <= r_cnt_drop_full + 32'd1;
         if (w_inc_rate) r_cnt_drop_rate <= r_cnt_drop_rate + 32'd1;
      end
   end

   assign bus.cnt_fwd       = r_cnt_fwd;
   assign bus.cnt_cpu       = r_cnt_cpu;
   assign bus.cnt_drop_full = r_cnt_drop_full;
   assign bus.cnt_drop_rate = r_cnt_drop_rate;

endmodule

`default_nettype wire
